muldiv_sched: RTL

- Sequencing controller for the shared multiply/divide unit and HI/LO registers. It sits beside the ID_EX pipeline register.
- Takes the EX-stage Start, MTHL, HiLo and MULDIV_Op controls. Times the multi-cycle operation and gates HI/LO write-enables.
- Generates the stall and ID_EX bubble for any ID-stage HI/LO user while the unit is occupied.
- Cancels an in-flight operation on an exception flush.

---
 rtl/muldiv_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/muldiv_sched.sv
// Sequences the shared mul/div unit, gates HI/LO write-enables and stalls ID-stage HI/LO users.
// Latency: unit_go combinational in the launch cycle; busy for N cycles after it, commit in the last one.
// Backpressure: holds stall_out/idex_flush_out while occupied; exc_flush cancels and overrides the stall.
module muldiv_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_in,
    input  logic [1:0] muldiv_op_in,
    input  logic       mthl_in,
    input  logic       hilo_in,
    input  logic       hl_use_id,
    input  logic       exc_flush,
    output logic       busy_out,
    output logic [1:0] op_out,
    output logic       unit_go,
    output logic       commit_out,
    output logic       hi_we,
    output logic       lo_we,
    output logic       stall_out,
    output logic       idex_flush_out
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter load values: the counter reaches zero in the last busy cycle.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [1:0] op_nxt;

    // Internal qualified conditions; reset_n gating keeps every output low while reset is held.
    logic is_idle;
    logic is_busy;
    logic launch;
    logic done;
    logic mt_hi;
    logic mt_lo;

    // State, countdown and latched op code register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_out <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_out <= op_nxt;
        end
    end

    // Next-state logic and output decode; a flush beats both completion and launch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        op_nxt         = op_out;

        is_idle        = reset_n & (state == IDLE);
        is_busy        = reset_n & (state == BUSY);
        launch         = is_idle & start_in & ~exc_flush;
        done           = is_busy & (cnt == 4'd0) & ~exc_flush;
        mt_hi          = is_idle & mthl_in & hilo_in & ~exc_flush;
        mt_lo          = is_idle & mthl_in & ~hilo_in & ~exc_flush;

        busy_out       = is_busy;
        unit_go        = launch;
        commit_out     = done;
        hi_we          = done | mt_hi;
        lo_we          = done | mt_lo;
        stall_out      = hl_use_id & (is_busy | launch) & ~exc_flush;
        idex_flush_out = stall_out;

        case (state)
            IDLE: begin
                if (start_in && !exc_flush) begin
                    state_nxt = BUSY;
                    op_nxt    = muldiv_op_in;
                    cnt_nxt   = muldiv_op_in[1] ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                // A start arriving here is a stall escape and is deliberately ignored.
                if (exc_flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule
